// File: rtl/iq_dispatch.sv
// Drains the instruction queue into a holding register, checks RAW/WAW hazards against
// a 32-entry scoreboard, and forwards through a registered valid/ready output stage.
// Optional macro IQ_DISPATCH_WB_BYPASS_EN: same-cycle writeback clears unblock consumers.
module iq_dispatch #(
    parameter int INSTR_W = 128,
    parameter int NUM_WB  = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  iq_empty_i,
    output logic                  iq_read_head_o,
    input  logic                  iq_valid_i,
    input  logic [INSTR_W-1:0]    iq_instr_i,
    input  logic [4:0]            iq_rs1_i,
    input  logic [4:0]            iq_rs2_i,
    input  logic [4:0]            iq_rd_i,
    input  logic                  iq_use_rs1_i,
    input  logic                  iq_use_rs2_i,
    input  logic                  iq_we_i,
    output logic                  rr_valid_o,
    output logic [INSTR_W-1:0]    rr_instr_o,
    output logic [4:0]            rr_rd_o,
    output logic                  rr_we_o,
    input  logic                  rr_ready_i,
    input  logic [NUM_WB-1:0]     wb_valid_i,
    input  logic [5*NUM_WB-1:0]   wb_rd_i,
    output logic                  hazard_stall_o
);
    // state  | meaning
    // IDLE   | holding register empty
    // LOADED | holding register valid, free to fire
    // HAZARD | holding register blocked by a RAW/WAW hazard
    typedef enum logic [1:0] {IDLE, LOADED, HAZARD} state_e;
    state_e state_q, state_d;

    logic               hold_v_q, hold_v_d;
    logic [INSTR_W-1:0] h_instr_q;
    logic [4:0]         h_rs1_q, h_rs2_q, h_rd_q;
    logic               h_use_rs1_q, h_use_rs2_q, h_we_q;

    logic               out_v_q, out_v_d;
    logic [INSTR_W-1:0] out_instr_q;
    logic [4:0]         out_rd_q;
    logic               out_we_q;

    logic [31:0] busy_q, busy_d, busy_reg, busy_eff, wb_clr;
    logic        out_free, hazard, fire, capture;

    always_comb begin
        wb_clr = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k]) wb_clr[wb_rd_i[5*k +: 5]] = 1'b1;
        end
    end

`ifdef IQ_DISPATCH_WB_BYPASS_EN
    assign busy_reg = busy_q & ~wb_clr;
`else
    assign busy_reg = busy_q;
`endif

    // The instruction sitting in the output stage has not set its busy bit yet.
    always_comb begin
        busy_eff = busy_reg;
        if (out_v_q && out_we_q) busy_eff[out_rd_q] = 1'b1;
        busy_eff[0] = 1'b0;
    end

    assign out_free = ~out_v_q | rr_ready_i;
    assign hazard   = hold_v_q & ((h_use_rs1_q & busy_eff[h_rs1_q]) |
                                  (h_use_rs2_q & busy_eff[h_rs2_q]) |
                                  (h_we_q      & busy_eff[h_rd_q]));
    assign fire     = hold_v_q & ~hazard & out_free & ~flush_i;

    assign iq_read_head_o = rstn_i & ~flush_i & ~iq_empty_i & (~hold_v_q | fire);
    assign capture        = iq_read_head_o & iq_valid_i;

    assign rr_valid_o     = out_v_q;
    assign rr_instr_o     = out_instr_q;
    assign rr_rd_o        = out_rd_q;
    assign rr_we_o        = out_we_q;
    assign hazard_stall_o = (state_q == HAZARD);

    always_comb begin
        hold_v_d = hold_v_q;
        if (flush_i)      hold_v_d = 1'b0;
        else if (capture) hold_v_d = 1'b1;
        else if (fire)    hold_v_d = 1'b0;

        out_v_d = out_v_q;
        if (flush_i)         out_v_d = 1'b0;
        else if (fire)       out_v_d = 1'b1;
        else if (rr_ready_i) out_v_d = 1'b0;
    end

    // Set wins over a same-cycle clear of the same index.
    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (rr_valid_o && rr_ready_i && rr_we_o && (rr_rd_o != 5'd0)) busy_d[rr_rd_o] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (capture) state_d = LOADED;
            LOADED: begin
                if (hazard)                state_d = HAZARD;
                else if (fire && !capture) state_d = IDLE;
            end
            HAZARD:  if (!hazard) state_d = (fire && !capture) ? IDLE : LOADED;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            hold_v_q    <= 1'b0;
            h_instr_q   <= '0;
            h_rs1_q     <= '0;
            h_rs2_q     <= '0;
            h_rd_q      <= '0;
            h_use_rs1_q <= 1'b0;
            h_use_rs2_q <= 1'b0;
            h_we_q      <= 1'b0;
            out_v_q     <= 1'b0;
            out_instr_q <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            busy_q      <= '0;
        end else begin
            state_q  <= state_d;
            hold_v_q <= hold_v_d;
            out_v_q  <= out_v_d;
            busy_q   <= busy_d;
            if (capture) begin
                h_instr_q   <= iq_instr_i;
                h_rs1_q     <= iq_rs1_i;
                h_rs2_q     <= iq_rs2_i;
                h_rd_q      <= iq_rd_i;
                h_use_rs1_q <= iq_use_rs1_i;
                h_use_rs2_q <= iq_use_rs2_i;
                h_we_q      <= iq_we_i;
            end
            if (fire) begin
                out_instr_q <= h_instr_q;
                out_rd_q    <= h_rd_q;
                out_we_q    <= h_we_q;
            end
        end
    end
endmodule

// File: tb/tb_iq_dispatch.sv
// Scoreboard bench for iq_dispatch: directed queue contents, expected outputs queued at push time
// and checked by an independent monitor; also directed cycle checks on handshake and stall timing.
module tb_iq_dispatch;
    localparam int INSTR_W = 128;
    localparam int NUM_WB  = 2;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [4:0]         rs1, rs2, rd;
        logic               u1, u2, we;
    } ent_t;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [4:0]         rd;
        logic               we;
    } exp_t;

    logic clk_i = 1'b0, rstn_i = 1'b0, flush_i = 1'b0, rr_ready_i = 1'b1;
    logic [NUM_WB-1:0]   wb_valid_i = '0;
    logic [5*NUM_WB-1:0] wb_rd_i = '0;
    logic iq_empty_i, iq_read_head_o, iq_valid_i;
    logic [INSTR_W-1:0] iq_instr_i, rr_instr_o;
    logic [4:0] iq_rs1_i, iq_rs2_i, iq_rd_i, rr_rd_o;
    logic iq_use_rs1_i, iq_use_rs2_i, iq_we_i, rr_valid_o, rr_we_o, hazard_stall_o;

    ent_t mem [64];
    logic [5:0] rd_ptr = '0, wr_cnt = '0;
    exp_t exp_q [$];
    int n_checks = 0, n_fail = 0;

    assign iq_empty_i   = (rd_ptr == wr_cnt);
    assign iq_valid_i   = iq_read_head_o & ~iq_empty_i;
    assign iq_instr_i   = mem[rd_ptr].instr;
    assign iq_rs1_i     = mem[rd_ptr].rs1;
    assign iq_rs2_i     = mem[rd_ptr].rs2;
    assign iq_rd_i      = mem[rd_ptr].rd;
    assign iq_use_rs1_i = mem[rd_ptr].u1;
    assign iq_use_rs2_i = mem[rd_ptr].u2;
    assign iq_we_i      = mem[rd_ptr].we;

    always @(posedge clk_i) if (iq_read_head_o && iq_valid_i) rd_ptr <= rd_ptr + 6'd1;

    always #5 clk_i = ~clk_i;

    iq_dispatch #(.INSTR_W(INSTR_W), .NUM_WB(NUM_WB)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .iq_empty_i(iq_empty_i), .iq_read_head_o(iq_read_head_o), .iq_valid_i(iq_valid_i),
        .iq_instr_i(iq_instr_i), .iq_rs1_i(iq_rs1_i), .iq_rs2_i(iq_rs2_i), .iq_rd_i(iq_rd_i),
        .iq_use_rs1_i(iq_use_rs1_i), .iq_use_rs2_i(iq_use_rs2_i), .iq_we_i(iq_we_i),
        .rr_valid_o(rr_valid_o), .rr_instr_o(rr_instr_o), .rr_rd_o(rr_rd_o), .rr_we_o(rr_we_o),
        .rr_ready_i(rr_ready_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .hazard_stall_o(hazard_stall_o)
    );

    function automatic logic [INSTR_W-1:0] pl(input int n);
        return {8'hA5, 88'h0, 32'(n)};
    endfunction

    task automatic chk(input string name, input logic [INSTR_W-1:0] act, input logic [INSTR_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int n, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic we, input logic expect_out);
        ent_t e;
        exp_t x;
        e = '{instr: pl(n), rs1: rs1, rs2: rs2, rd: rd, u1: u1, u2: u2, we: we};
        mem[wr_cnt] = e;
        wr_cnt = wr_cnt + 6'd1;
        if (expect_out) begin
            x.instr = pl(n);
            x.rd    = rd;
            x.we    = we;
            exp_q.push_back(x);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every accepted output must match the oldest expected entry.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk_i);
            if (rstn_i && rr_valid_o && rr_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", rr_instr_o, '1);
                end else begin
                    x = exp_q.pop_front();
                    chk("sb_instr", rr_instr_o, x.instr);
                    chk("sb_rd", 128'(rr_rd_o), 128'(x.rd));
                    chk("sb_we", 128'(rr_we_o), 128'(x.we));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #12;
        chk("rst_rr_valid", 128'(rr_valid_o), 0);
        chk("rst_rr_instr", rr_instr_o, 0);
        chk("rst_rr_rd", 128'(rr_rd_o), 0);
        chk("rst_rr_we", 128'(rr_we_o), 0);
        chk("rst_read_head", 128'(iq_read_head_o), 0);
        chk("rst_stall", 128'(hazard_stall_o), 0);
        #10 rstn_i = 1'b1;
        step();

        // three independent instructions, back to back
        push(1, 5'd0, 5'd0, 5'd1, 0, 0, 0, 1);
        push(2, 5'd0, 5'd0, 5'd2, 0, 0, 0, 1);
        push(3, 5'd0, 5'd0, 5'd3, 0, 0, 0, 1);
        #1;
        chk("t1_rh_c0", 128'(iq_read_head_o), 1);
        chk("t1_v_c0", 128'(rr_valid_o), 0);
        step(); chk("t1_rh_c1", 128'(iq_read_head_o), 1); chk("t1_v_c1", 128'(rr_valid_o), 0);
        step(); chk("t1_rh_c2", 128'(iq_read_head_o), 1); chk("t1_v_c2", 128'(rr_valid_o), 1);
        step(); chk("t1_rh_c3", 128'(iq_read_head_o), 0); chk("t1_v_c3", 128'(rr_valid_o), 1);
        step(); chk("t1_v_c4", 128'(rr_valid_o), 1);
        step(); chk("t1_v_c5", 128'(rr_valid_o), 0);
        steps(2);

        // RAW on x5, writeback four cycles after A is accepted
        push(10, 5'd0, 5'd0, 5'd5, 0, 0, 1, 1);
        push(11, 5'd5, 5'd0, 5'd6, 1, 0, 0, 1);
        push(12, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        step();
        step(); chk("t2_rh_c2", 128'(iq_read_head_o), 0);
        step(); chk("t2_stall_c3", 128'(hazard_stall_o), 1); chk("t2_rh_c3", 128'(iq_read_head_o), 0);
        step(); chk("t2_stall_c4", 128'(hazard_stall_o), 1);
        step(); chk("t2_stall_c5", 128'(hazard_stall_o), 1); chk("t2_rh_c5", 128'(iq_read_head_o), 0);
        step();
        wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd5};
        #1;
`ifdef IQ_DISPATCH_WB_BYPASS_EN
        chk("t2_rh_wb", 128'(iq_read_head_o), 1);
        step(); wb_valid_i = '0; chk("t2_v_wb1", 128'(rr_valid_o), 1);
`else
        chk("t2_rh_wb", 128'(iq_read_head_o), 0);
        step(); wb_valid_i = '0; chk("t2_v_wb1", 128'(rr_valid_o), 0);
`endif
        step(); chk("t2_v_wb2", 128'(rr_valid_o), 1);
        steps(4);

        // backpressure with both stages full
        push(20, 5'd0, 5'd0, 5'd1, 0, 0, 0, 1);
        push(21, 5'd0, 5'd0, 5'd1, 0, 0, 0, 1);
        push(22, 5'd0, 5'd0, 5'd1, 0, 0, 0, 1);
        push(23, 5'd0, 5'd0, 5'd1, 0, 0, 0, 1);
        steps(3);
        rr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_bp_valid", 128'(rr_valid_o), 1);
            chk("t3_bp_instr", rr_instr_o, pl(21));
            chk("t3_bp_rh", 128'(iq_read_head_o), 0);
            step();
        end
        rr_ready_i = 1'b1;
        #1;
        chk("t3_rel_instr", rr_instr_o, pl(21));
        chk("t3_rel_rh", 128'(iq_read_head_o), 1);
        step(); chk("t3_instr_p2", rr_instr_o, pl(22)); chk("t3_v_p2", 128'(rr_valid_o), 1);
        step(); chk("t3_instr_p3", rr_instr_o, pl(23)); chk("t3_v_p3", 128'(rr_valid_o), 1);
        step(); chk("t3_v_end", 128'(rr_valid_o), 0);
        steps(2);

        // flush while LOADED; busy[7] survives the flush
        push(30, 5'd0, 5'd0, 5'd7, 0, 0, 1, 1);
        steps(4);
        rr_ready_i = 1'b0;
        push(31, 5'd0, 5'd0, 5'd2, 0, 0, 0, 0);
        push(32, 5'd0, 5'd0, 5'd2, 0, 0, 0, 0);
        step();
        step();
        flush_i = 1'b1;
        #1;
        chk("t4_pre_flush_valid", 128'(rr_valid_o), 1);
        chk("t4_flush_stall", 128'(hazard_stall_o), 0);
        step();
        flush_i = 1'b0;
        #1;
        chk("t4_post_valid", 128'(rr_valid_o), 0);
        rr_ready_i = 1'b1;
        push(33, 5'd7, 5'd0, 5'd4, 1, 0, 0, 1);
        #1;
        chk("t4_hold_empty_rh", 128'(iq_read_head_o), 1);
        step();
        step(); chk("t4_busy7_stall", 128'(hazard_stall_o), 1);
        wb_valid_i = 2'b10; wb_rd_i = {5'd7, 5'd0};
        step(); wb_valid_i = '0;
        steps(4);

        // same-cycle set and clear of x9: set wins
        push(40, 5'd0, 5'd0, 5'd9, 0, 0, 1, 1);
        step();
        step();
        wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd9};
        #1;
        chk("t5_accept_v", 128'(rr_valid_o), 1);
        step();
        wb_valid_i = '0;
        push(41, 5'd0, 5'd9, 5'd8, 0, 1, 0, 1);
        step();
        step(); chk("t5_busy9_stall", 128'(hazard_stall_o), 1);
        wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd9};
        step(); wb_valid_i = '0;
        steps(4);

        // x0 is never busy
        push(50, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        push(51, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1);
        step();
        step(); chk("t5_x0_v_c2", 128'(rr_valid_o), 1); chk("t5_x0_stall_c2", 128'(hazard_stall_o), 0);
        step(); chk("t5_x0_v_c3", 128'(rr_valid_o), 1); chk("t5_x0_instr_c3", rr_instr_o, pl(51));
        step(); chk("t5_x0_stall_c4", 128'(hazard_stall_o), 0);
        steps(2);

        // reset mid-stream
        push(60, 5'd0, 5'd0, 5'd12, 0, 0, 1, 1);
        push(61, 5'd0, 5'd0, 5'd1, 0, 0, 0, 0);
        push(62, 5'd0, 5'd0, 5'd1, 0, 0, 0, 0);
        push(63, 5'd12, 5'd0, 5'd1, 1, 0, 0, 1);
        steps(3);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_valid", 128'(rr_valid_o), 0);
        chk("t6_rst_instr", rr_instr_o, 0);
        chk("t6_rst_rd", 128'(rr_rd_o), 0);
        chk("t6_rst_we", 128'(rr_we_o), 0);
        chk("t6_rst_rh", 128'(iq_read_head_o), 0);
        chk("t6_rst_stall", 128'(hazard_stall_o), 0);
        #1 rstn_i = 1'b1;
        step(); chk("t6_d0_stall", 128'(hazard_stall_o), 0);
        step(); chk("t6_d1_valid", 128'(rr_valid_o), 1); chk("t6_d1_instr", rr_instr_o, pl(63));
        steps(3);

        chk("sb_drained", 128'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iq_dispatch.md
Name: iq_dispatch

Overview:
- Consumer-side controller for the instruction queue; drains the queue head toward the register-read (RR) stage.
- Pops one instruction per cycle into a holding register and checks RAW/WAW hazards against a 32-entry register scoreboard.
- Forwards hazard-free instructions through a registered valid/ready output stage.
- The queue returns data only in the cycle its pop is requested, so this block never peeks; it always pops into its own holding register.

Parameters:
- INSTR_W, 128, width of opaque instruction payload.
- NUM_WB, 2, number of writeback ports that clear scoreboard bits.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill holding and output stages.
- iq_empty_i  in  1  queue empty.
- iq_read_head_o  out  1  pop request to queue.
- iq_valid_i  in  1  popped instruction valid (same cycle as pop).
- iq_instr_i  in  INSTR_W  popped payload.
- iq_rs1_i, iq_rs2_i, iq_rd_i  in  5 each  register indices.
- iq_use_rs1_i, iq_use_rs2_i, iq_we_i  in  1 each  operand use / rd write.
- rr_valid_o  out  1  output instruction valid.
- rr_instr_o  out  INSTR_W  output payload.
- rr_rd_o  out  5  output destination.
- rr_we_o  out  1  output writes rd.
- rr_ready_i  in  1  RR accepts.
- wb_valid_i  in  NUM_WB  writeback port valid.
- wb_rd_i  in  5*NUM_WB  writeback rd, port k at bits [5k+4:5k].
- hazard_stall_o  out  1  holding register blocked by hazard this cycle.

Behaviour:
- Reset: hold_v=0, out_v=0, busy=32'h0, FSM=IDLE. All outputs 0: rr_valid_o, rr_instr_o, rr_rd_o, rr_we_o, iq_read_head_o, hazard_stall_o.
- out_free = ~out_v | rr_ready_i.
- hazard = hold_v & ((use_rs1 & busy_eff[rs1]) | (use_rs2 & busy_eff[rs2]) | (we & busy_eff[rd])).
  - An output-stage match also counts as busy: out_v & out_we & out_rd==idx.
  - Index 0 is never busy.
- fire = hold_v & ~hazard & out_free & ~flush_i.
- iq_read_head_o = ~flush_i & ~iq_empty_i & (~hold_v | fire). Combinational.
- Capture: if iq_read_head_o & iq_valid_i, the holding register loads all iq_* fields and hold_v<=1. Else if fire, hold_v<=0.
- Output stage: on fire, loads from the holding register and out_v<=1. Else if rr_ready_i, out_v<=0. Payload holds its value while stalled.
- Scoreboard:
  - On rr_valid_o & rr_ready_i & rr_we_o & rr_rd_o!=0, set busy[rr_rd_o].
  - On wb_valid_i[k], clear busy[wb_rd_i[k]].
  - Same-cycle set and clear of the same index: set wins.
- Minimum latency: pop in cycle N -> hold_v in N+1 -> rr_valid_o in N+2. Sustained throughput is 1/cycle with no hazards.
- FSM (observable via hazard_stall_o and iq_read_head_o):
  - IDLE (hold empty) -> LOADED on capture.
  - LOADED -> IDLE on fire without a new capture; stays LOADED on fire with a capture.
  - LOADED -> HAZARD when hazard=1. hazard_stall_o=1 only in HAZARD.
  - HAZARD -> LOADED once the hazard clears.
  - Any state -> IDLE on flush_i.
- flush_i (sync): clears hold_v and out_v next cycle and suppresses pop and fire in the flush cycle.
  - busy is NOT cleared: instructions already accepted by RR still write back.
- Reset mid-operation: all state returns to reset values asynchronously.
- Backpressure: with rr_ready_i=0 and out_v=1, the holding register keeps its value and no pop occurs.

Optional Feature:
- Macro: IQ_DISPATCH_WB_BYPASS_EN.
- Defined: busy_eff = busy & ~(same-cycle wb clears). A consumer may fire in the same cycle as the producer's writeback.
- Undefined: busy_eff = busy (registered only). A consumer fires no earlier than the cycle after writeback.

Test Plan:
- Three independent instructions in the queue, rr_ready_i=1 -> iq_read_head_o high 3 consecutive cycles; rr_valid_o high cycles 2,3,4; payloads in order.
- Instr A writes x5 and is accepted. Instr B reads rs1=x5. wb_valid_i[0]=1 with wb_rd_i=5 arrives 4 cycles later.
  - B holds with hazard_stall_o=1 and iq_read_head_o=0.
  - B fires in the wb cycle with the bypass macro, or the cycle after without it.
- rr_ready_i=0 for 3 cycles with out_v=1 and hold_v=1 -> rr_instr_o stable, iq_read_head_o=0, no queue pop. On release, one output per cycle resumes.
- flush_i during the LOADED state with busy[7]=1 -> next cycle rr_valid_o=0 and hold empty; busy[7] remains 1 until wb_rd_i=7.
- Same cycle: accept instr with rd=x9 and wb_rd_i=9 -> busy[9]=1 afterward. Instr with rd=x0 -> no busy bit set, no stall on x0 reads.
- Assert rstn_i=0 mid-stream -> all outputs 0 immediately; after release the FSM is IDLE and busy=0.
